// File: rtl/truth_table_scanner.sv
// Exhaustive truth-table scanner: walks every N_IN-bit vector into a combinational
// function-under-test and records its 1-bit response, plus ones count and first hit.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start; results of the last scan stay visible
// S_SCAN | driving dut_in, counting SETTLE wait cycles, capturing dut_out
// S_DONE | one-cycle completion state carrying the done pulse
module truth_table_scanner #(
   parameter int N_IN   = 5,
   parameter int SETTLE = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
   input  logic                 abort_i,
   output logic [N_IN-1:0]      dut_in_o,
   input  logic                 dut_out_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [2**N_IN-1:0]   table_o,
   output logic [N_IN:0]        ones_count_o,
   output logic [N_IN-1:0]      first_one_o,
   output logic                 found_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [3:0]      SETTLE_C = 4'(SETTLE);
   localparam logic [N_IN-1:0] LAST_VEC = {N_IN{1'b1}};
   localparam logic [N_IN-1:0] ONE_VEC  = N_IN'(1);
   localparam logic [N_IN:0]   ONE_CNT  = (N_IN+1)'(1);

   state_t              state_q;
   logic [3:0]          wait_q;
   logic [N_IN-1:0]     dut_in_q;
   logic                busy_q;
   logic                done_q;
   logic [2**N_IN-1:0]  table_q;
   logic [N_IN:0]       ones_q;
   logic [N_IN-1:0]     first_q;
   logic                found_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         wait_q   <= '0;
         dut_in_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         table_q  <= '0;
         ones_q   <= '0;
         first_q  <= '0;
         found_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               // start beats a simultaneous abort here since abort is ignored in IDLE
               if (start_i) begin
                  state_q  <= S_SCAN;
                  dut_in_q <= '0;
                  wait_q   <= SETTLE_C;
                  table_q  <= '0;
                  ones_q   <= '0;
                  first_q  <= '0;
                  found_q  <= 1'b0;
                  busy_q   <= 1'b1;
               end
            end
            S_SCAN: begin
               if (abort_i) begin
                  // partial results are kept; the vector under sample is dropped
                  state_q  <= S_IDLE;
                  busy_q   <= 1'b0;
                  dut_in_q <= '0;
               end else if (wait_q != 4'd0) begin
                  wait_q <= wait_q - 4'd1;
               end else begin
                  table_q[dut_in_q] <= dut_out_i;
                  if (dut_out_i) begin
                     ones_q <= ones_q + ONE_CNT;
                     if (!found_q) begin
                        first_q <= dut_in_q;
                        found_q <= 1'b1;
                     end
                  end
                  if (dut_in_q != LAST_VEC) begin
                     dut_in_q <= dut_in_q + ONE_VEC;
                     wait_q   <= SETTLE_C;
                  end else begin
                     state_q <= S_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign dut_in_o     = dut_in_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign table_o      = table_q;
   assign ones_count_o = ones_q;
   assign first_one_o  = first_q;
   assign found_o      = found_q;

endmodule
